// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: block-cipher mode controller (ECB / CBC / CTR) that drives an
// iterative AES-128 core one 128-bit block at a time, owning the IV/counter
// chaining register, the remaining-block counter and the streaming handshakes.
// Optional build macro: AES_MODE_CTRL_CHAIN_OUT_EN exposes the chaining
// register on o_Chain for message resumption.
module aes_mode_ctrl #(
    parameter int CTR_W = 32,
    parameter int LEN_W = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic [1:0]       i_Mode,
    input  logic             i_fDec,
    input  logic [127:0]     i_IV,
    input  logic [LEN_W-1:0] i_NumBlk,
    input  logic             i_Din_Valid,
    input  logic [127:0]     i_Din,
    output logic             o_Din_Ready,
    output logic             o_Dout_Valid,
    output logic [127:0]     o_Dout,
    input  logic             i_Dout_Ready,
    output logic             o_Busy,
    output logic             o_fDone,
    output logic             o_fErr,
    output logic             o_Core_Start,
    output logic             o_Core_fDec,
    output logic [127:0]     o_Core_Text,
    input  logic             i_Core_fDone,
    input  logic [127:0]     i_Core_Text
`ifdef AES_MODE_CTRL_CHAIN_OUT_EN
    ,
    output logic [127:0]     o_Chain
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CORE,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_ECB = 2'b00;
    localparam logic [1:0] MODE_CBC = 2'b01;
    localparam logic [1:0] MODE_CTR = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    // Bits of the chaining register that form the CTR block counter.
    localparam logic [127:0] CTR_MASK =
        (CTR_W >= 128) ? {128{1'b1}} : ((128'd1 << CTR_W) - 128'd1);

    state_t             state_reg, state_next;
    logic [1:0]         mode_reg, mode_next;
    logic               dec_reg, dec_next;
    logic [LEN_W-1:0]   rem_reg, rem_next;
    logic [127:0]       chain_reg, chain_next;
    logic [127:0]       in_reg, in_next;
    logic [127:0]       text_reg, text_next;
    logic [127:0]       dout_reg, dout_next;
    logic               core_start_reg, core_start_next;
    logic               err_reg, err_next;
    logic [127:0]       chain_inc;

    // Counter increment confined to the low CTR_W bits; the carry out of the
    // counter field is discarded so the upper nonce bits never change.
    assign chain_inc = (chain_reg & ~CTR_MASK) | ((chain_reg + 128'd1) & CTR_MASK);

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg      <= S_IDLE;
            mode_reg       <= MODE_ECB;
            dec_reg        <= 1'b0;
            rem_reg        <= '0;
            chain_reg      <= '0;
            in_reg         <= '0;
            text_reg       <= '0;
            dout_reg       <= '0;
            core_start_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mode_reg       <= mode_next;
            dec_reg        <= dec_next;
            rem_reg        <= rem_next;
            chain_reg      <= chain_next;
            in_reg         <= in_next;
            text_reg       <= text_next;
            dout_reg       <= dout_next;
            core_start_reg <= core_start_next;
            err_reg        <= err_next;
        end
    end

    // Next-state and datapath update for each mode.
    always_comb begin
        state_next      = state_reg;
        mode_next       = mode_reg;
        dec_next        = dec_reg;
        rem_next        = rem_reg;
        chain_next      = chain_reg;
        in_next         = in_reg;
        text_next       = text_reg;
        dout_next       = dout_reg;
        core_start_next = 1'b0;
        err_next        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (i_Start) begin
                    mode_next  = i_Mode;
                    dec_next   = i_fDec;
                    rem_next   = i_NumBlk;
                    chain_next = i_IV;
                    if (i_Mode == MODE_RSV) begin
                        err_next = 1'b1;
                    end else if (i_NumBlk == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (i_Din_Valid) begin
                    in_next = i_Din;
                    case (mode_reg)
                        MODE_CBC: text_next = dec_reg ? i_Din : (i_Din ^ chain_reg);
                        MODE_CTR: text_next = chain_reg;
                        default:  text_next = i_Din;
                    endcase
                    core_start_next = 1'b1;
                    state_next      = S_CORE;
                end
            end
            S_CORE: begin
                if (i_Core_fDone) begin
                    case (mode_reg)
                        MODE_CBC: begin
                            if (dec_reg) begin
                                dout_next  = i_Core_Text ^ chain_reg;
                                chain_next = in_reg;
                            end else begin
                                dout_next  = i_Core_Text;
                                chain_next = i_Core_Text;
                            end
                        end
                        MODE_CTR: begin
                            dout_next  = i_Core_Text ^ in_reg;
                            chain_next = chain_inc;
                        end
                        default: dout_next = i_Core_Text;
                    endcase
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (i_Dout_Ready) begin
                    rem_next   = rem_reg - LEN_W'(1);
                    state_next = (rem_reg == LEN_W'(1)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // All handshake outputs decode registered state only.
    assign o_Din_Ready  = (state_reg == S_LOAD);
    assign o_Dout_Valid = (state_reg == S_OUT);
    assign o_Dout       = (state_reg == S_OUT) ? dout_reg : '0;
    assign o_Busy       = (state_reg != S_IDLE);
    assign o_fDone      = (state_reg == S_DONE);
    assign o_fErr       = err_reg;
    assign o_Core_Start = core_start_reg;
    assign o_Core_fDec  = dec_reg & (mode_reg != MODE_CTR);
    assign o_Core_Text  = text_reg;

`ifdef AES_MODE_CTRL_CHAIN_OUT_EN
    assign o_Chain = chain_reg;
`endif

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Testbench for aes_mode_ctrl: a stub cipher core answers known AES-128
// vectors by lookup and otherwise applies a fixed XOR, so expected outputs
// are derived from published vectors and simple bench arithmetic.
module tb_aes_mode_ctrl;

    localparam logic [127:0] PT     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] ECB_CT = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] IV_CBC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CBC_CT = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] IV_CTR = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] CTR_CT = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CTR2   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] KX     = 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
    localparam logic [127:0] D2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] W_IV   = {96'h111111111111111111111111, 32'hffffffff};
    localparam logic [127:0] W2     = {96'h111111111111111111111111, 32'h00000000};

    logic         clk = 1'b0;
    logic         i_Rst = 1'b1;
    logic         i_Start = 1'b0;
    logic [1:0]   i_Mode = 2'b00;
    logic         i_fDec = 1'b0;
    logic [127:0] i_IV = '0;
    logic [15:0]  i_NumBlk = '0;
    logic         i_Din_Valid = 1'b0;
    logic [127:0] i_Din = '0;
    logic         i_Dout_Ready = 1'b0;
    logic         o_Din_Ready, o_Dout_Valid, o_Busy, o_fDone, o_fErr;
    logic         o_Core_Start, o_Core_fDec;
    logic [127:0] o_Dout, o_Core_Text;
    logic         core_done = 1'b0;
    logic [127:0] core_out = '0;

    logic         ident = 1'b0;
    logic         core_busy = 1'b0;
    logic [2:0]   core_cnt = '0;
    logic [127:0] core_res = '0;
    int           start_cnt = 0;
    int           done_cnt = 0;
    int           checks = 0;
    int           errors = 0;

    aes_mode_ctrl dut (
        .i_Clk        (clk),
        .i_Rst        (i_Rst),
        .i_Start      (i_Start),
        .i_Mode       (i_Mode),
        .i_fDec       (i_fDec),
        .i_IV         (i_IV),
        .i_NumBlk     (i_NumBlk),
        .i_Din_Valid  (i_Din_Valid),
        .i_Din        (i_Din),
        .o_Din_Ready  (o_Din_Ready),
        .o_Dout_Valid (o_Dout_Valid),
        .o_Dout       (o_Dout),
        .i_Dout_Ready (i_Dout_Ready),
        .o_Busy       (o_Busy),
        .o_fDone      (o_fDone),
        .o_fErr       (o_fErr),
        .o_Core_Start (o_Core_Start),
        .o_Core_fDec  (o_Core_fDec),
        .o_Core_Text  (o_Core_Text),
        .i_Core_fDone (core_done),
        .i_Core_Text  (core_out)
    );

    always #5 clk = ~clk;

    // Stub core transform: known-answer lookup, identity, or fixed XOR.
    function automatic logic [127:0] stub_f(input logic [127:0] t, input logic d, input logic id);
        if (id) return t;
        if (!d && t == PT) return ECB_CT;
        if (!d && t == (PT ^ IV_CBC)) return CBC_CT;
        if (d && t == CBC_CT) return PT ^ IV_CBC;
        if (!d && t == IV_CTR) return CTR_CT ^ PT;
        return t ^ KX;
    endfunction

    // Stub core: result pulse four cycles after its start pulse; it does not
    // see the controller reset, so an aborted job still answers late.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (o_Core_Start) begin
            core_busy <= 1'b1;
            core_cnt  <= 3'd3;
            core_res  <= stub_f(o_Core_Text, o_Core_fDec, ident);
            start_cnt <= start_cnt + 1;
        end else if (core_busy) begin
            core_cnt <= core_cnt - 3'd1;
            if (core_cnt == 3'd1) begin
                core_busy <= 1'b0;
                core_done <= 1'b1;
                core_out  <= core_res;
                done_cnt  <= done_cnt + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic start_msg(input logic [1:0] m, input logic d, input logic [127:0] iv, input logic [15:0] nb);
        i_Mode   = m;
        i_fDec   = d;
        i_IV     = iv;
        i_NumBlk = nb;
        i_Start  = 1'b1;
        @(negedge clk);
        i_Start  = 1'b0;
    endtask

    task automatic send_din(input logic [127:0] din, input logic [127:0] exp_text, input logic exp_fdec);
        int n = 0;
        while (!o_Din_Ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("din_ready", 128'(o_Din_Ready), 128'd1);
        i_Din_Valid = 1'b1;
        i_Din       = din;
        @(negedge clk);
        i_Din_Valid = 1'b0;
        check("core_start_latency", 128'(o_Core_Start), 128'd1);
        check("core_text", o_Core_Text, exp_text);
        check("core_fdec", 128'(o_Core_fDec), 128'(exp_fdec));
        @(negedge clk);
        check("core_start_single", 128'(o_Core_Start), 128'd0);
        check("core_text_hold", o_Core_Text, exp_text);
    endtask

    task automatic recv_dout(input logic [127:0] exp, input int hold, input string nm);
        int n = 0;
        int s;
        while (!core_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("core_done_seen", 128'(core_done), 128'd1);
        check("dout_early", 128'(o_Dout_Valid), 128'd0);
        @(negedge clk);
        check("dout_latency", 128'(o_Dout_Valid), 128'd1);
        s = start_cnt;
        for (int h = 0; h < hold; h++) begin
            check("dout_hold", {o_Dout_Valid, o_Dout[126:0]}, {1'b1, exp[126:0]});
            @(negedge clk);
        end
        check("no_core_start_hold", 128'(start_cnt), 128'(s));
        check("dout", o_Dout, exp);
        $display("blk %s dout=%h exp=%h", nm, o_Dout, exp);
        i_Dout_Ready = 1'b1;
        @(negedge clk);
        i_Dout_Ready = 1'b0;
    endtask

    task automatic end_msg(input string nm);
        check({nm, "_done"}, {126'd0, o_fDone, o_Busy}, 128'd3);
        @(negedge clk);
        check({nm, "_idle"}, {126'd0, o_fDone, o_Busy}, 128'd0);
    endtask

    typedef struct {
        logic [1:0]   mode;
        logic         dec;
        logic [127:0] iv;
        logic [127:0] din;
        logic [127:0] exp_text;
        logic         exp_fdec;
        logic [127:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int s;
        int d;
        vecs[0] = '{2'b00, 1'b0, '0,     PT,     PT,          1'b0, ECB_CT};
        vecs[1] = '{2'b01, 1'b0, IV_CBC, PT,     PT ^ IV_CBC, 1'b0, CBC_CT};
        vecs[2] = '{2'b01, 1'b1, IV_CBC, CBC_CT, CBC_CT,      1'b1, PT};
        vecs[3] = '{2'b10, 1'b0, IV_CTR, PT,     IV_CTR,      1'b0, CTR_CT};
        vecs[4] = '{2'b10, 1'b1, IV_CTR, PT,     IV_CTR,      1'b0, CTR_CT};
        vecs[5] = '{2'b00, 1'b1, '0,     D2,     D2,          1'b1, D2 ^ KX};

        repeat (3) @(negedge clk);
        check("reset_ctrl", {121'd0, o_Busy, o_Din_Ready, o_Dout_Valid, o_fDone, o_fErr,
                             o_Core_Start, o_Core_fDec}, 128'd0);
        i_Rst = 1'b0;
        @(negedge clk);
        check("reset_dout", o_Dout, 128'd0);
        check("reset_core_text", o_Core_Text, 128'd0);

        // Single-block messages, one per table row.
        for (int i = 0; i < 6; i++) begin
            start_msg(vecs[i].mode, vecs[i].dec, vecs[i].iv, 16'd1);
            send_din(vecs[i].din, vecs[i].exp_text, vecs[i].exp_fdec);
            recv_dout(vecs[i].exp_dout, 0, $sformatf("vec%0d", i));
            end_msg("vec");
        end

        // CTR two blocks: counter advances in its low 32 bits.
        start_msg(2'b10, 1'b0, IV_CTR, 16'd2);
        send_din(PT, IV_CTR, 1'b0);
        recv_dout(CTR_CT, 0, "ctr1");
        check("next_ready_latency", {126'd0, o_fDone, o_Din_Ready}, 128'd1);
        send_din(D2, CTR2, 1'b0);
        recv_dout(CTR2 ^ KX ^ D2, 0, "ctr2");
        end_msg("ctr2blk");

        // CBC encrypt chaining: block 2 is XORed with block 1 ciphertext.
        start_msg(2'b01, 1'b0, IV_CBC, 16'd2);
        send_din(PT, PT ^ IV_CBC, 1'b0);
        recv_dout(CBC_CT, 0, "cbce1");
        send_din(D2, D2 ^ CBC_CT, 1'b0);
        recv_dout(D2 ^ CBC_CT ^ KX, 0, "cbce2");
        end_msg("cbce2blk");

        // CBC decrypt chaining: block 2 output is XORed with block 1 input.
        start_msg(2'b01, 1'b1, IV_CBC, 16'd2);
        send_din(CBC_CT, CBC_CT, 1'b1);
        recv_dout(PT, 0, "cbcd1");
        send_din(D2, D2, 1'b1);
        recv_dout(D2 ^ KX ^ CBC_CT, 0, "cbcd2");
        end_msg("cbcd2blk");

        // Counter wrap with an identity core.
        ident = 1'b1;
        start_msg(2'b10, 1'b0, W_IV, 16'd2);
        send_din('0, W_IV, 1'b0);
        recv_dout(W_IV, 0, "wrap1");
        send_din('0, W2, 1'b0);
        recv_dout(W2, 0, "wrap2");
        end_msg("wrap");
        ident = 1'b0;

        // Backpressure on block 1, then abort during CORE of block 2.
        start_msg(2'b00, 1'b0, '0, 16'd2);
        send_din(D2, D2, 1'b0);
        recv_dout(D2 ^ KX, 5, "bp1");
        send_din(PT, PT, 1'b0);
        d = done_cnt;
        i_Rst = 1'b1;
        @(negedge clk);
        i_Rst = 1'b0;
        check("abort_busy", 128'(o_Busy), 128'd0);
        for (int k = 0; k < 8; k++) begin
            check("abort_no_out", {o_fDone, o_Dout_Valid, o_Dout[125:0]}, 128'd0);
            @(negedge clk);
        end
        check("abort_late_core_done", 128'(done_cnt), 128'(d + 1));
        $display("abort done");

        // Reserved mode.
        s = start_cnt;
        start_msg(2'b11, 1'b0, '0, 16'd5);
        check("err_pulse", {126'd0, o_fErr, o_Busy}, 128'd2);
        @(negedge clk);
        check("err_clear", {125'd0, o_fErr, o_Busy, o_Din_Ready}, 128'd0);
        $display("rsv mode err checked");

        // Zero-length message.
        start_msg(2'b00, 1'b0, '0, 16'd0);
        end_msg("zero_len");
        check("zero_len_no_core", 128'(start_cnt), 128'(s));
        $display("zero length checked");

        // Controller still usable after all of the above.
        start_msg(2'b00, 1'b0, '0, 16'd1);
        send_din(PT, PT, 1'b0);
        recv_dout(ECB_CT, 0, "final_ecb");
        end_msg("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
